// File: rtl/ones_mod_pkg.sv
// Shared definitions for the ones-count modulus tracker: counting modes and
// the residue/wrap-counter widths.
package ones_mod_pkg;

    localparam int MODE_LEVEL = 0;
    localparam int MODE_EDGE  = 1;
    localparam int WRAP_CNT_W = 8;

    // A modulus of 2 still needs one residue bit.
    function automatic int residue_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/ones_mod_channel.sv
// One tracker channel: input synchronizer, optional rising-edge detect,
// residue counter modulo MODULUS and a saturating wrap counter.
module ones_mod_channel
    import ones_mod_pkg::*;
#(
    parameter int MODULUS = 2,
    parameter int MODE    = MODE_LEVEL
) (
    input  logic                            gclk,
    input  logic                            resetn,
    input  logic                            in_bit,
    input  logic                            en,
    input  logic                            clr,
    output logic [residue_width(MODULUS)-1:0] residue,
    output logic                            wrap_pulse,
    output logic [WRAP_CNT_W-1:0]           wrap_count
);

    localparam int RW      = residue_width(MODULUS);
    localparam bit IS_POW2 = ((MODULUS & (MODULUS - 1)) == 0);

    // Declaration values give the FPGA the same power-up state as reset.
    logic                  s1_q = 1'b0;
    logic                  s2_q = 1'b0;
    logic                  s3_q = 1'b0;
    logic [RW-1:0]         residue_q = '0;
    logic                  wrap_pulse_q = 1'b0;
    logic [WRAP_CNT_W-1:0] wrap_count_q = '0;

    logic                  s1_d;
    logic                  s2_d;
    logic                  s3_d;
    logic [RW-1:0]         residue_d;
    logic                  wrap_pulse_d;
    logic [WRAP_CNT_W-1:0] wrap_count_d;
    logic                  count_ev;
    logic                  at_top;

    always_comb begin
        s1_d         = in_bit;
        s2_d         = s1_q;
        s3_d         = s2_q;
        residue_d    = residue_q;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        count_ev     = (MODE == MODE_EDGE) ? (s2_q & ~s3_q) : s2_q;
        at_top       = (residue_q == RW'(MODULUS - 1));

        // A clear wins over a same-cycle event; the event is dropped.
        if (clr) begin
            residue_d    = '0;
            wrap_count_d = '0;
        end else if (en && count_ev) begin
            if (IS_POW2) begin
                residue_d = residue_q + 1'b1;
            end else begin
                residue_d = at_top ? '0 : residue_q + 1'b1;
            end
            if (at_top) begin
                wrap_pulse_d = 1'b1;
                if (wrap_count_q != '1) begin
                    wrap_count_d = wrap_count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (!resetn) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            residue_q    <= '0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            residue_q    <= residue_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign residue    = residue_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: rtl/ones_mod_tracker.sv
// Multi-channel ones-count modulus tracker; each channel is an independent
// ones_mod_channel with its own clear.
module ones_mod_tracker
    import ones_mod_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODULUS  = 2,
    parameter int MODE     = MODE_LEVEL
) (
    input  logic                                       gclk,
    input  logic                                       resetn,
    input  logic [CHANNELS-1:0]                        in_bits,
    input  logic                                       en,
    input  logic [CHANNELS-1:0]                        clr,
    output logic [CHANNELS*residue_width(MODULUS)-1:0] residue,
    output logic [CHANNELS-1:0]                        is_zero,
    output logic [CHANNELS-1:0]                        wrap_pulse,
    output logic [CHANNELS*WRAP_CNT_W-1:0]             wrap_count
);

    localparam int RW = residue_width(MODULUS);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            ones_mod_channel #(
                .MODULUS (MODULUS),
                .MODE    (MODE)
            ) u_ch (
                .gclk       (gclk),
                .resetn     (resetn),
                .in_bit     (in_bits[gi]),
                .en         (en),
                .clr        (clr[gi]),
                .residue    (residue[gi*RW +: RW]),
                .wrap_pulse (wrap_pulse[gi]),
                .wrap_count (wrap_count[gi*WRAP_CNT_W +: WRAP_CNT_W])
            );

            assign is_zero[gi] = (residue[gi*RW +: RW] == '0);
        end
    endgenerate

endmodule

// File: doc/ones_mod_tracker.md
ONES_MOD_TRACKER -- requirements
Module: ones_mod_tracker

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of independent input channels (1..16).
REQ-002 SHALL have parameter MODULUS, default 2, meaning ones-count modulus per channel (2..256).
REQ-003 SHALL have parameter MODE, default MODE_LEVEL, meaning MODE_LEVEL counts every cycle the input is high and MODE_EDGE counts rising edges only.
REQ-004 SHALL derive RW = max(1, clog2(MODULUS)) as the residue width.
REQ-005 SHALL have port gclk  input  1  clock; all logic on posedge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_bits  input  CHANNELS  asynchronous per-channel data bits.
REQ-008 SHALL have port en  input  1  global count enable.
REQ-009 SHALL have port clr  input  CHANNELS  per-channel synchronous clear.
REQ-010 SHALL have port residue  output  CHANNELS*RW  per-channel ones count mod MODULUS; channel i in bits [i*RW +: RW].
REQ-011 SHALL have port is_zero  output  CHANNELS  high when the channel residue is 0 (the even flag when MODULUS=2).
REQ-012 SHALL have port wrap_pulse  output  CHANNELS  one-cycle pulse when a residue rolls from MODULUS-1 to 0.
REQ-013 SHALL have port wrap_count  output  CHANNELS*8  per-channel saturating wrap counter.

Function
REQ-014 SHALL pass each in_bits through a 2-flop synchronizer (s1, s2); only s2 feeds counting logic.
REQ-015 SHALL, in MODE_EDGE, keep a history flop s3 = previous s2 and define the count event as s2 & ~s3; in MODE_LEVEL, the count event is s2.
REQ-016 SHALL, when en=1 and a count event occurs, update residue to (residue+1) mod MODULUS on that edge; otherwise residue holds.
REQ-017 SHALL make a sustained level high at in_bits first sampled at edge k increment residue at edge k+2 (MODE_LEVEL) and again on every later edge while it stays high and en=1.
REQ-018 SHALL keep the synchronizer and edge-history flops running while en=0; an edge that occurs while en=0 SHALL be lost, not deferred.
REQ-019 SHALL, on the wrap from MODULUS-1 to 0, assert wrap_pulse for exactly the following cycle (registered) and increment wrap_count.
REQ-020 SHALL saturate wrap_count at 255 with no rollover; a wrap at 255 SHALL still pulse wrap_pulse.
REQ-021 SHALL give clr[i] priority over a simultaneous count event: residue and wrap_count go to 0, wrap_pulse goes to 0, and the event is discarded; synchronizer flops are unaffected.
REQ-022 SHALL drive is_zero combinationally from the registered residue (no extra latency).
REQ-023 SHALL keep channels fully independent; a clr or event on one channel SHALL NOT affect another channel.
REQ-024 SHALL, when MODULUS is a power of two, allow natural wrap; otherwise it SHALL compare explicitly against MODULUS-1.

Reset
REQ-025 SHALL, on resetn=0 at a clock edge, set residue=0, is_zero=all ones, wrap_pulse=0, wrap_count=0, and s1/s2/s3=0.
REQ-026 SHALL give reset priority over clr and en; reset mid-count SHALL discard in-flight synchronizer contents.
REQ-027 SHALL initialise the same values at configuration time for FPGA power-up.

Structure
REQ-028 SHALL place MODE_LEVEL=0, MODE_EDGE=1 and WRAP_CNT_W=8 in shared package ones_mod_pkg.
REQ-029 SHALL implement one sub-module ones_mod_channel (synchronizer, edge detect, residue, wrap logic) instantiated CHANNELS times by generate.

Verification
REQ-030 SHALL cover: default params, ch0 held high for 5 cycles with en=1 -> residue0 toggles 1,0,1,0,1 starting 2 edges after first sample; is_zero0 ends 0; wrap_count0=2.
REQ-031 SHALL cover: MODULUS=5, MODE_EDGE, 7 isolated pulses on ch2 -> residue2=2, one wrap_pulse2 on the 5th edge, wrap_count2=1.
REQ-032 SHALL cover: clr1 asserted in the same cycle as ch1 event with residue1=1 (MODULUS=2) -> residue1=0, wrap_pulse1=0, wrap_count1=0.
REQ-033 SHALL cover: en=0 during 3 pulses then en=1 (MODE_EDGE) -> residue unchanged by those pulses.
REQ-034 SHALL cover: 300 wraps on ch3 -> wrap_count3=255, and the 300th wrap still pulses.
REQ-035 SHALL cover: resetn low mid-stream for 1 cycle -> all outputs at reset values next cycle, and a pulse in the synchronizer is not counted.
